// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, opcodes, function codes and instruction field positions for the CPU control path
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] OPC_R    = 3'b000;
  localparam logic [2:0] OPC_ADDI = 3'b001;
  localparam logic [2:0] OPC_SUBI = 3'b010;
  localparam logic [2:0] OPC_ST   = 3'b011;
  localparam logic [2:0] OPC_LD   = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_SLT = 4'b0011;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_NOT = 4'b0110;
  localparam logic [3:0] FN_XOR = 4'b0111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int FUNC_MSB = 3;
  localparam int FUNC_LSB = 0;

endpackage

// File: rtl/cpu_ctrl_dec.sv
// rtl/cpu_ctrl_dec.sv - combinational instruction decoder: IR to ALU code and instruction class flags
module cpu_ctrl_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  alu_code,
  output logic        is_r,
  output logic        is_imm,
  output logic        is_ld,
  output logic        is_st,
  output logic        is_halt,
  output logic        illegal
);

  logic [2:0] opc;
  logic [3:0] func;
  logic       unused_fields;

  assign opc  = ir[OPC_MSB:OPC_LSB];
  assign func = ir[FUNC_MSB:FUNC_LSB];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_fields = ^ir[OPC_LSB-1:FUNC_MSB+1];

  always_comb begin
    alu_code = ALU_ADD;
    is_r     = 1'b0;
    is_imm   = 1'b0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    is_halt  = 1'b0;
    illegal  = 1'b0;
    case (opc)
      OPC_R: begin
        is_r = 1'b1;
        case (func)
          FN_ADD:  alu_code = ALU_ADD;
          FN_SUB:  alu_code = ALU_SUB;
          FN_SLT:  alu_code = ALU_SLT;
          FN_AND:  alu_code = ALU_AND;
          FN_OR:   alu_code = ALU_OR;
          FN_NOT:  alu_code = ALU_NOT;
          FN_XOR:  alu_code = ALU_XOR;
          default: illegal  = 1'b1;
        endcase
      end
      OPC_ADDI: is_imm = 1'b1;
      OPC_SUBI: begin
        is_imm   = 1'b1;
        alu_code = ALU_SUB;
      end
      OPC_ST: begin
        is_imm = 1'b1;
        is_st  = 1'b1;
      end
      OPC_LD: begin
        is_imm = 1'b1;
        is_ld  = 1'b1;
      end
      OPC_HALT: is_halt = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle CPU control FSM with mem_ack timeout
// Optional retired-instruction counter enabled by CPU_CTRL_RETIRE_CNT_EN.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        pc_load,
  output logic [2:0]  alu_code,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        reg_wsel,
  output logic        illegal_op,
  output logic        bus_err,
  output logic        halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0] retired
`endif
);

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] wait_q, wait_d;
  logic        bus_err_q, bus_err_d;

  logic [2:0]  dec_alu_code;
  logic        dec_is_r, dec_is_imm, dec_is_ld, dec_is_st, dec_is_halt, dec_illegal;

  cpu_ctrl_dec u_dec (
    .ir       (ir_q),
    .alu_code (dec_alu_code),
    .is_r     (dec_is_r),
    .is_imm   (dec_is_imm),
    .is_ld    (dec_is_ld),
    .is_st    (dec_is_st),
    .is_halt  (dec_is_halt),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    wait_d       = '0;
    bus_err_d    = bus_err_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    alu_code     = ALU_ADD;
    alu_src_b    = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    reg_wsel     = 1'b0;
    illegal_op   = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_load = mem_ack;
        if (mem_ack) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_op = 1'b1;
          state_d    = ST_FETCH;
        end else if (dec_is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_code  = dec_alu_code;
        alu_src_b = dec_is_imm;
        reg_dst   = dec_is_r;
        reg_wsel  = dec_is_ld;
        state_d   = (dec_is_ld || dec_is_st) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_is_st;
        alu_code     = dec_alu_code;
        alu_src_b    = dec_is_imm;
        reg_dst      = dec_is_r;
        reg_wsel     = dec_is_ld;
        if (mem_ack) state_d = dec_is_st ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_we    = 1'b1;
        alu_code  = dec_alu_code;
        alu_src_b = dec_is_imm;
        reg_dst   = dec_is_r;
        reg_wsel  = dec_is_ld;
        state_d   = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_RST;
    endcase

    // Waiting states only hold while unacked, so the count naturally clears on any state change.
    if (mem_req && !mem_ack) begin
      if ((MAX_WAIT > 0) && (wait_q == WAIT_LAST)) begin
        bus_err_d = 1'b1;
        state_d   = ST_HALT;
      end else begin
        wait_d = wait_q + 16'd1;
      end
    end
  end

  assign bus_err = bus_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      ir_q      <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;

  // A store retires on its memory ack; everything else that writes retires leaving WB.
  always_comb begin
    retired_d = retired_q;
    if ((state_q == ST_WB) || ((state_q == ST_MEM) && mem_ack && dec_is_st)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - table-driven scoreboard bench for cpu_ctrl_fsm, including reset, halt and timeout sequences
module tb_cpu_ctrl_fsm;

  logic        clk, rst_n;
  logic [15:0] instr;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
  logic [2:0]  alu_code;
  logic        alu_src_b, reg_we, reg_dst, reg_wsel, illegal_op, bus_err, halted;
`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  cpu_ctrl_fsm #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_load      (pc_load),
    .alu_code     (alu_code),
    .alu_src_b    (alu_src_b),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .reg_wsel     (reg_wsel),
    .illegal_op   (illegal_op),
    .bus_err      (bus_err),
    .halted       (halted)
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    .retired      (retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          mem_delay;
    int          lat;
    logic        fetch_ok;
    logic [2:0]  alu;
    logic        src_b;
    int          we_cnt;
    logic        dst;
    logic        wsel;
    logic        mem_we;
    int          mem_cyc;
    int          ill_cnt;
    int          retire;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];
  vec_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_ret = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {mem_req, mem_we, mem_addr_sel, ir_load, pc_load, alu_code, alu_src_b,
            reg_we, reg_dst, reg_wsel, illegal_op, bus_err, halted};
  endfunction

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench positioned in the first FETCH cycle after reset.
  task automatic do_reset(input string tag);
    next_cyc();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1 chk({tag, ".rst_outs"}, 32'(outs()), 32'd0);
    next_cyc();
    rst_n = 1'b1;
    #1 chk({tag, ".rst_state"}, 32'(outs()), 32'd0);
    next_cyc();
    chk({tag, ".first_fetch"}, {30'd0, mem_req, mem_addr_sel}, 32'b10);
    exp_ret = 0;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    chk({tag, ".retired_reset"}, 32'(retired), 32'd0);
`endif
  endtask

  task automatic run_vec(input int idx);
    vec_t v, o, e;
    int   cyc, memcnt;
    bit   done;
    string tag;
    v = vecs[idx];
    o = '{default: 0};
    cyc = 0;
    memcnt = 0;
    done = 0;
    tag = $sformatf("v%0d", idx);
    while (!done) begin
      if (cyc > 0) next_cyc();
      if ((cyc > 0 && mem_req && !mem_addr_sel) || halted || cyc >= 30) begin
        done = 1;
      end else begin
        if (cyc == 0) begin
          instr   = v.instr;
          mem_ack = 1'b1;
          sb_q.push_back(v);
        end else if (mem_req) begin
          mem_ack = (memcnt == v.mem_delay);
          memcnt++;
        end else begin
          mem_ack = 1'b0;
        end
        #1;
        cyc++;
        if (cyc == 1) o.fetch_ok = mem_req & ~mem_addr_sel & ir_load & pc_load;
        if (cyc == 3) begin
          o.alu   = alu_code;
          o.src_b = alu_src_b;
        end
        if (reg_we) begin
          o.we_cnt++;
          o.dst  = reg_dst;
          o.wsel = reg_wsel;
        end
        if (mem_we) o.mem_we = 1'b1;
        if (illegal_op) o.ill_cnt++;
      end
    end
    mem_ack   = 1'b0;
    o.lat     = cyc;
    o.mem_cyc = memcnt;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".lat"},      32'(o.lat),      32'(e.lat));
      chk({tag, ".fetch"},    32'(o.fetch_ok), 32'(e.fetch_ok));
      chk({tag, ".alu"},      32'(o.alu),      32'(e.alu));
      chk({tag, ".src_b"},    32'(o.src_b),    32'(e.src_b));
      chk({tag, ".reg_we"},   32'(o.we_cnt),   32'(e.we_cnt));
      chk({tag, ".reg_dst"},  32'(o.dst),      32'(e.dst));
      chk({tag, ".reg_wsel"}, 32'(o.wsel),     32'(e.wsel));
      chk({tag, ".mem_we"},   32'(o.mem_we),   32'(e.mem_we));
      chk({tag, ".mem_cyc"},  32'(o.mem_cyc),  32'(e.mem_cyc));
      chk({tag, ".illegal"},  32'(o.ill_cnt),  32'(e.ill_cnt));
      exp_ret += e.retire;
`ifdef CPU_CTRL_RETIRE_CNT_EN
      chk({tag, ".retired"}, 32'(retired), 32'(exp_ret & 16'hFFFF));
`endif
    end
  endtask

  initial begin
    //           instr     dly lat ok  alu     sb  we dst wsel mwe mc ill ret
    vecs[0]  = '{16'h0530, 0,  4, 1, 3'b000, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[1]  = '{16'h8485, 3,  8, 1, 3'b000, 1, 1, 0, 1, 0, 4, 0, 1};
    vecs[2]  = '{16'h6485, 0,  4, 1, 3'b000, 1, 0, 0, 0, 1, 1, 0, 1};
    vecs[3]  = '{16'hA000, 0,  2, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{16'h0002, 0,  2, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[5]  = '{16'h4485, 0,  4, 1, 3'b001, 1, 1, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{16'h0531, 0,  4, 1, 3'b001, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[7]  = '{16'h0533, 0,  4, 1, 3'b011, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[8]  = '{16'h0534, 0,  4, 1, 3'b100, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[9]  = '{16'h0535, 0,  4, 1, 3'b101, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[10] = '{16'h0536, 0,  4, 1, 3'b110, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[11] = '{16'h0537, 0,  4, 1, 3'b111, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[12] = '{16'h2485, 0,  4, 1, 3'b000, 1, 1, 0, 0, 0, 0, 0, 1};
    vecs[13] = '{16'h0538, 0,  2, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[14] = '{16'hC000, 0,  2, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[15] = '{16'h8485, 0,  5, 1, 3'b000, 1, 1, 0, 1, 0, 1, 0, 1};
    vecs[16] = '{16'h6485, 2,  6, 1, 3'b000, 1, 0, 0, 0, 1, 3, 0, 1};

    rst_n   = 1'b0;
    instr   = 16'h0000;
    mem_ack = 1'b0;
    do_reset("init");

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset while a load waits in MEM with its ack still outstanding.
    instr   = 16'h8485;
    mem_ack = 1'b1;
    next_cyc();
    mem_ack = 1'b0;
    next_cyc();
    next_cyc();
    chk("midmem.in_mem", {29'd0, mem_req, mem_addr_sel, mem_we}, 32'b110);
    do_reset("midmem");

    // HALT instruction: outputs stay quiet except halted, whatever the inputs do.
    instr   = 16'hE000;
    mem_ack = 1'b1;
    next_cyc();
    mem_ack = 1'b0;
    #1 chk("halt.decode", 32'(outs()), 32'd0);
    next_cyc();
    mem_ack = 1'b1;
    #1 chk("halt.enter", 32'(outs()), 32'd1);
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      mem_ack = 1'($urandom_range(1));
      instr   = 16'($urandom);
      #1 chk($sformatf("halt.quiet%0d", k), 32'(outs()), 32'd1);
    end
    do_reset("halt");

    // mem_ack never arrives in FETCH: timeout after MAX_WAIT=4 cycles.
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cyc();
      chk($sformatf("to.wait%0d", k), {29'd0, mem_req, bus_err, halted}, 32'b100);
    end
    next_cyc();
    chk("to.trip", {29'd0, mem_req, bus_err, halted}, 32'b011);
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      chk($sformatf("to.sticky%0d", k), 32'(outs()), 32'b11);
    end
    do_reset("to");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
